nv_nvdla_mcif_write_arb: RTL and testbench
==========================================

NV_NVDLA_MCIF_WRITE_ARB -- requirements
Module: nv_nvdla_mcif_write_arb

Interface
REQ-001 Parameter NUM_CLIENTS, default 4, number of write-DMA requesters (2..8).
REQ-002 Parameter ID_W, default 3, width of granted-client index (ceil(log2(NUM_CLIENTS)), minimum 1).
REQ-003 nvdla_core_clk  input  1  single clock; all state on rising edge.
REQ-004 nvdla_core_rstn  input  1  reset, synchronous, active-high (asserted = 1).
REQ-005 reg2dp_wr_os_cnt  input  8  outstanding limit; allowed beats = value+1 (1..256).
REQ-006 reg2dp_wr_weight  input  8*NUM_CLIENTS  per-client WRR weight, client i at bits [8i+7:8i]; 0 = client disabled.
REQ-007 client_req_valid  input  NUM_CLIENTS  per-client request valid.
REQ-008 client_req_len  input  2*NUM_CLIENTS  per-client burst length, beats-1, client i at [2i+1:2i].
REQ-009 client_req_ready  output  NUM_CLIENTS  per-client accept, at most one bit high per cycle.
REQ-010 arb_out_vld / arb_out_rdy  output / input  1 / 1  granted-request handshake toward ingress.
REQ-011 arb_out_id  output  ID_W  index of granted client.
REQ-012 arb_out_len  output  2  beats-1 of granted request.
REQ-013 eg2ig_axi_vld / eg2ig_axi_len  input  1 / 2  write-response return; releases len+1 beats.
REQ-014 os_cnt  output  9  current outstanding beats.
REQ-015 os_err  output  1  sticky underflow flag.

Function
REQ-016 Eligible(i) SHALL = client_req_valid[i] & weight_i!=0 & (os_cnt + len_i + 1 <= reg2dp_wr_os_cnt + 1), 10-bit compare, no wrap.
REQ-017 Load condition SHALL be (!arb_out_vld | arb_out_rdy) & any eligible client.
REQ-018 On load, winner's client_req_ready SHALL be high that cycle (combinational); id/len registered; arb_out_vld=1 next cycle (latency 1).
REQ-019 arb_out_vld/id/len SHALL hold stable while arb_out_vld & !arb_out_rdy; arb_out_vld drops only on accept with no new load.
REQ-020 Back-to-back: accept and load in same cycle SHALL give arb_out_vld continuously high with new id/len.
REQ-021 State: last winner ptr (ID_W) and burst_cnt (8 bit).
REQ-022 Priority 1: last winner eligible & burst_cnt < its weight -> grant last winner, burst_cnt+1.
REQ-023 Priority 2: otherwise first eligible client searching from ptr+1 upward with wrap; ptr=winner, burst_cnt=1.
REQ-024 If only last winner eligible and burst exhausted, it SHALL win via search (burst_cnt=1).
REQ-025 No load -> ptr and burst_cnt unchanged.
REQ-026 os_cnt_next SHALL = os_cnt + (load ? len+1 : 0) - (eg2ig_axi_vld ? eg2ig_axi_len+1 : 0), both same cycle allowed.
REQ-027 Eligibility SHALL use registered os_cnt only (returns free credit next cycle).
REQ-028 If decrement exceeds os_cnt + increment, os_cnt SHALL saturate to 0 and os_err SHALL set, held until reset.
REQ-029 Lowering reg2dp_wr_os_cnt below os_cnt SHALL only block new loads; no flush.
REQ-030 Weight change SHALL take effect on next arbitration.

Reset
REQ-031 While nvdla_core_rstn=1: arb_out_vld=0, arb_out_id=0, arb_out_len=0, os_cnt=0, os_err=0, ptr=NUM_CLIENTS-1, burst_cnt=0, client_req_ready=0.
REQ-032 Reset mid-transaction SHALL drop pending grant and credit with no ready pulse; first grant after reset searches from client 0.

Verification
REQ-033 Weights {2,1,1,1}, all valid len=0, rdy=1, os=255 -> grants 0,0,1,2,3,0,0,... one per cycle.
REQ-034 os=3 (4 beats), client0 len=3 valid, no returns -> one grant, os_cnt=4, then blocked; eg2ig vld len=3 -> next grant one cycle later.
REQ-035 arb_out_rdy=0 for 5 cycles with grant pending -> id/len stable, no client_req_ready pulse; rdy=1 -> next grant same edge.
REQ-036 Weight1=0, client1 only valid -> no grant, os_cnt unchanged.
REQ-037 os_cnt=1, eg2ig len=1 with no load -> os_cnt=0, os_err=1 sticky until reset.
REQ-038 Reset asserted mid-burst with arb_out_vld=1 -> all outputs 0 next cycle; after release first winner is lowest-index eligible.

Source files
------------

// File: rtl/nv_nvdla_mcif_write_arb.sv
// nv_nvdla_mcif_write_arb
// Weighted round-robin arbiter for the MCIF write path. Selects one write-DMA
// client per cycle, forwards its burst (id/len) to ingress through a one-entry
// output register, and tracks outstanding write beats against a programmable
// limit so new bursts are only issued when their beats fit.
//
// Ports
//   nvdla_core_clk    clock, all state on the rising edge
//   nvdla_core_rstn   synchronous reset, active-high
//   reg2dp_wr_os_cnt  outstanding limit, allowed beats = value+1
//   reg2dp_wr_weight  per-client WRR weight (8 bits each), 0 disables a client
//   client_req_valid  per-client request valid
//   client_req_len    per-client burst length, beats-1 (2 bits each)
//   client_req_ready  per-client accept, combinational, one-hot or zero
//   arb_out_vld/rdy   granted-request handshake toward ingress
//   arb_out_id        index of the granted client
//   arb_out_len       beats-1 of the granted burst
//   eg2ig_axi_vld/len write-response return, releases len+1 beats
//   os_cnt            current outstanding beats
//   os_err            sticky outstanding-counter underflow flag
module nv_nvdla_mcif_write_arb #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned ID_W        = 3
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rstn,
    input  logic [7:0]                 reg2dp_wr_os_cnt,
    input  logic [8*NUM_CLIENTS-1:0]   reg2dp_wr_weight,
    input  logic [NUM_CLIENTS-1:0]     client_req_valid,
    input  logic [2*NUM_CLIENTS-1:0]   client_req_len,
    output logic [NUM_CLIENTS-1:0]     client_req_ready,
    output logic                       arb_out_vld,
    input  logic                       arb_out_rdy,
    output logic [ID_W-1:0]            arb_out_id,
    output logic [1:0]                 arb_out_len,
    input  logic                       eg2ig_axi_vld,
    input  logic [1:0]                 eg2ig_axi_len,
    output logic [8:0]                 os_cnt,
    output logic                       os_err
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned CMP_W = 10;
    localparam int unsigned LEN_W = 2;
    localparam int unsigned WGT_W = 8;

    logic                 rst;
    logic                 vld_q, vld_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [CNT_W-1:0]     os_q, os_d;
    logic                 err_q, err_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [WGT_W-1:0]     burst_q, burst_d;

    logic [NUM_CLIENTS-1:0] elig;
    logic                 last_elig;
    logic [WGT_W-1:0]     last_wgt;
    logic                 hi_found;
    logic [ID_W-1:0]      hi_idx;
    logic [ID_W-1:0]      lo_idx;
    logic                 keep_last;
    logic                 load;
    logic [ID_W-1:0]      win_idx;
    logic [LEN_W-1:0]     win_len;
    logic [CMP_W-1:0]     os_sum;
    logic [CMP_W-1:0]     os_ret;

    assign rst = nvdla_core_rstn;

    // A client is eligible when it is valid, enabled and its whole burst fits
    // in the remaining credit (10-bit compare so 256 beats cannot wrap).
    always_comb begin
        elig = '0;
        for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
            elig[i] = client_req_valid[i]
                   && (reg2dp_wr_weight[WGT_W*i +: WGT_W] != 8'd0)
                   && ((CMP_W'(os_q) + CMP_W'(client_req_len[LEN_W*i +: LEN_W]) + 10'd1)
                       <= (CMP_W'(reg2dp_wr_os_cnt) + 10'd1));
        end
    end

    // Last-winner lookup plus a wrap-around search starting at ptr+1: the
    // lowest eligible index above ptr wins, else the lowest at or below ptr.
    always_comb begin
        last_elig = 1'b0;
        last_wgt  = '0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = int'(NUM_CLIENTS) - 1; i >= 0; i--) begin
            if (ID_W'(i) == ptr_q) begin
                last_elig = elig[i];
                last_wgt  = reg2dp_wr_weight[WGT_W*i +: WGT_W];
            end
            if (elig[i]) begin
                if (ID_W'(i) > ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end else begin
                    lo_idx   = ID_W'(i);
                end
            end
        end
    end

    // burst_q==0 means no previous winner (after reset), so the search from
    // ptr+1 = client 0 decides the first grant.
    assign keep_last = (burst_q != 8'd0) && last_elig && (burst_q < last_wgt);
    assign load      = !rst && (!vld_q || arb_out_rdy) && (|elig);
    assign win_idx   = keep_last ? ptr_q : (hi_found ? hi_idx : lo_idx);

    // Winner's burst length and one-hot accept strobe.
    always_comb begin
        win_len          = '0;
        client_req_ready = '0;
        for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
            if (ID_W'(i) == win_idx) begin
                win_len             = client_req_len[LEN_W*i +: LEN_W];
                client_req_ready[i] = load;
            end
        end
    end

    // Next state: output register, WRR pointer/burst count, credit counter.
    always_comb begin
        vld_d   = vld_q;
        id_d    = id_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        err_d   = err_q;
        os_d    = os_q;

        if (load) begin
            vld_d   = 1'b1;
            id_d    = win_idx;
            len_d   = win_len;
            ptr_d   = win_idx;
            burst_d = keep_last ? (burst_q + 8'd1) : 8'd1;
        end else if (arb_out_rdy) begin
            vld_d   = 1'b0;
        end

        os_sum = CMP_W'(os_q) + (load ? (CMP_W'(win_len) + 10'd1) : 10'd0);
        os_ret = eg2ig_axi_vld ? (CMP_W'(eg2ig_axi_len) + 10'd1) : 10'd0;
        if (os_ret > os_sum) begin
            os_d  = '0;
            err_d = 1'b1;
        end else begin
            os_d  = CNT_W'(os_sum - os_ret);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            id_q    <= '0;
            len_q   <= '0;
            os_q    <= '0;
            err_q   <= 1'b0;
            ptr_q   <= ID_W'(NUM_CLIENTS - 1);
            burst_q <= '0;
        end else begin
            vld_q   <= vld_d;
            id_q    <= id_d;
            len_q   <= len_d;
            os_q    <= os_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
        end
    end

    assign arb_out_vld = vld_q;
    assign arb_out_id  = id_q;
    assign arb_out_len = len_q;
    assign os_cnt      = os_q;
    assign os_err      = err_q;

endmodule

// File: tb/tb_nv_nvdla_mcif_write_arb.sv
// Testbench for nv_nvdla_mcif_write_arb: directed scenarios plus randomized
// traffic, checked every cycle against a transaction-level model of the
// weighted round-robin arbiter and its credit counter.
module tb_nv_nvdla_mcif_write_arb;

    localparam int N  = 4;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        os_lim;
    logic [8*N-1:0]    wgt;
    logic [N-1:0]      vld;
    logic [2*N-1:0]    len;
    logic [N-1:0]      rdy;
    logic              out_vld;
    logic              out_rdy;
    logic [IW-1:0]     out_id;
    logic [1:0]        out_len;
    logic              eg_vld;
    logic [1:0]        eg_len;
    logic [8:0]        os;
    logic              err;

    int checks = 0;
    int errors = 0;
    int grant_q[$];

    // Model state (current) and predicted next state.
    int m_os = 0, m_ptr = N - 1, m_burst = 0, m_id = 0, m_len = 0;
    bit m_err = 0, m_vld = 0;
    int n_os = 0, n_ptr = N - 1, n_burst = 0, n_id = 0, n_len = 0;
    bit n_err = 0, n_vld = 0;

    always #5 clk = ~clk;

    nv_nvdla_mcif_write_arb #(.NUM_CLIENTS(N), .ID_W(IW)) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rst),
        .reg2dp_wr_os_cnt (os_lim),
        .reg2dp_wr_weight (wgt),
        .client_req_valid (vld),
        .client_req_len   (len),
        .client_req_ready (rdy),
        .arb_out_vld      (out_vld),
        .arb_out_rdy      (out_rdy),
        .arb_out_id       (out_id),
        .arb_out_len      (out_len),
        .eg2ig_axi_vld    (eg_vld),
        .eg2ig_axi_len    (eg_len),
        .os_cnt           (os),
        .os_err           (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wgt_of(input int c);
        return int'(wgt[8*c +: 8]);
    endfunction

    function automatic int len_of(input int c);
        return int'(len[2*c +: 2]);
    endfunction

    function automatic bit elig(input int c);
        return vld[c] && (wgt_of(c) != 0) && (m_os + len_of(c) + 1 <= int'(os_lim) + 1);
    endfunction

    // Winner under the WRR rules, -1 if nobody is eligible.
    function automatic int pick(output bit kept);
        int c;
        kept = 1'b0;
        if (m_burst > 0 && elig(m_ptr) && m_burst < wgt_of(m_ptr)) begin
            kept = 1'b1;
            return m_ptr;
        end
        for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (elig(c)) return c;
        end
        return -1;
    endfunction

    // Compare outputs and predict the next state away from the active edge.
    always @(negedge clk) begin
        int  win;
        bit  kept;
        bit  load;
        int  s, d;
        logic [N-1:0] exp_rdy;

        chk("arb_out_vld", 32'(out_vld), 32'(m_vld));
        chk("arb_out_id",  32'(out_id),  32'(m_id));
        chk("arb_out_len", 32'(out_len), 32'(m_len));
        chk("os_cnt",      32'(os),      32'(m_os));
        chk("os_err",      32'(err),     32'(m_err));

        win  = pick(kept);
        load = !rst && (!m_vld || out_rdy) && (win >= 0);
        exp_rdy = '0;
        if (load) exp_rdy[win] = 1'b1;
        chk("client_req_ready", 32'(rdy), 32'(exp_rdy));

        for (int i = 0; i < N; i++) if (rdy[i]) grant_q.push_back(i);

        if (rst) begin
            n_os = 0; n_err = 0; n_vld = 0; n_id = 0; n_len = 0; n_ptr = N - 1; n_burst = 0;
        end else begin
            s = m_os + (load ? len_of(win) + 1 : 0);
            d = eg_vld ? int'(eg_len) + 1 : 0;
            n_err = m_err;
            if (d > s) begin
                n_os = 0; n_err = 1;
            end else begin
                n_os = s - d;
            end
            n_vld = load ? 1'b1 : (out_rdy ? 1'b0 : m_vld);
            n_id = m_id; n_len = m_len; n_ptr = m_ptr; n_burst = m_burst;
            if (load) begin
                n_id = win; n_len = len_of(win); n_ptr = win;
                n_burst = kept ? m_burst + 1 : 1;
            end
        end
    end

    always @(posedge clk) begin
        m_os = n_os; m_err = n_err; m_vld = n_vld; m_id = n_id;
        m_len = n_len; m_ptr = n_ptr; m_burst = n_burst;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        grant_q.delete();
    endtask

    initial begin
        int exp_seq[7];
        exp_seq = '{0, 0, 1, 2, 3, 0, 0};
        rst = 1'b1; os_lim = 8'd255; wgt = '0; vld = '0; len = '0;
        out_rdy = 1'b1; eg_vld = 1'b0; eg_len = '0;
        step(3);
        @(negedge clk);
        chk("reset os_cnt", 32'(os), 32'd0);
        chk("reset vld", 32'(out_vld), 32'd0);
        chk("reset ptr-search ready", 32'(rdy), 32'd0);
        step(1);

        // Weighted rotation 2,1,1,1 with one grant per cycle.
        wgt = {8'd1, 8'd1, 8'd1, 8'd2}; vld = 4'hF; len = '0; os_lim = 8'd255;
        do_reset();
        rst = 1'b0;
        step(7);
        vld = '0;
        chk("wrr grant count", 32'(grant_q.size() >= 7), 32'd1);
        if (grant_q.size() >= 7)
            for (int i = 0; i < 7; i++) chk("wrr grant order", 32'(grant_q[i]), 32'(exp_seq[i]));

        // Credit limit: 4 beats allowed, one 4-beat burst, then blocked.
        do_reset();
        wgt = {8'd1, 8'd1, 8'd1, 8'd1}; os_lim = 8'd3; vld = 4'b0001; len = 8'b0000_0011;
        rst = 1'b0;
        step(6);
        @(negedge clk);
        chk("credit one grant", 32'(grant_q.size()), 32'd1);
        chk("credit os_cnt", 32'(os), 32'd4);
        step(1);
        eg_vld = 1'b1; eg_len = 2'd3;
        step(1);
        eg_vld = 1'b0;
        step(2);
        chk("credit regrant", 32'(grant_q.size()), 32'd2);
        chk("credit os_cnt again", 32'(os), 32'd4);

        // Reset with a pending grant, then lowest eligible wins.
        rst = 1'b1;
        step(1);
        @(negedge clk);
        chk("midreset vld", 32'(out_vld), 32'd0);
        chk("midreset os_cnt", 32'(os), 32'd0);
        chk("midreset ready", 32'(rdy), 32'd0);
        step(1);
        grant_q.delete();
        os_lim = 8'd255; vld = 4'b0110; len = '0;
        rst = 1'b0;
        step(2);
        vld = '0;
        chk("post-reset first winner", 32'(grant_q.size() > 0 ? grant_q[0] : -1), 32'd1);

        // Backpressure: grant held stable, no accept strobes while stalled.
        do_reset();
        vld = 4'b0001; len = 8'b0000_0010; out_rdy = 1'b0;
        rst = 1'b0;
        step(6);
        @(negedge clk);
        chk("stall grants", 32'(grant_q.size()), 32'd1);
        chk("stall id", 32'(out_id), 32'd0);
        chk("stall len", 32'(out_len), 32'd2);
        chk("stall vld", 32'(out_vld), 32'd1);
        step(1);
        out_rdy = 1'b1;
        step(1);
        vld = '0;
        @(negedge clk);
        chk("stall release grant", 32'(grant_q.size()), 32'd2);
        step(1);

        // Disabled client never granted.
        do_reset();
        wgt = {8'd1, 8'd1, 8'd0, 8'd1}; vld = 4'b0010;
        rst = 1'b0;
        step(5);
        @(negedge clk);
        chk("disabled grants", 32'(grant_q.size()), 32'd0);
        chk("disabled os_cnt", 32'(os), 32'd0);
        step(1);

        // Underflow: os_cnt=1, return of 2 beats saturates and sets sticky err.
        do_reset();
        wgt = {8'd1, 8'd1, 8'd1, 8'd1}; vld = 4'b0001; len = '0;
        rst = 1'b0;
        step(1);
        vld = '0;
        step(1);
        eg_vld = 1'b1; eg_len = 2'd1;
        step(1);
        eg_vld = 1'b0;
        @(negedge clk);
        chk("underflow os_cnt", 32'(os), 32'd0);
        chk("underflow err", 32'(err), 32'd1);
        step(5);
        chk("underflow err sticky", 32'(err), 32'd1);
        do_reset();
        @(negedge clk);
        chk("err cleared", 32'(err), 32'd0);
        step(1);

        // Randomized traffic.
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 150 == 0) begin
                for (int i = 0; i < N; i++)
                    wgt[8*i +: 8] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
                case ($urandom_range(0, 4))
                    0: os_lim = 8'd0;
                    1: os_lim = 8'd3;
                    2: os_lim = 8'd7;
                    3: os_lim = 8'd255;
                    default: os_lim = 8'($urandom_range(0, 40));
                endcase
            end
            vld     = N'($urandom);
            len     = (2*N)'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            eg_len  = 2'($urandom);
            eg_vld  = ($urandom_range(0, 2) == 0) &&
                      ((m_os >= int'(eg_len) + 1) || ($urandom_range(0, 200) == 0));
            rst     = ($urandom_range(0, 400) == 0);
            step(1);
        end
        rst = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
